// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder.
// Optional random stall generation is enabled with LC3_MEM_RANDOM_STALL_EN.
package lc3_mem_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// Instruction and data memory bus between the LC3 core (master)
// and the memory responder (slave).
interface lc3_mem_responder_if;
  import lc3_mem_pkg::*;

  word_t pc;
  logic  instrmem_rd;
  logic  I_macc;
  word_t Instr_dout;
  logic  complete_instr;
  word_t Data_addr;
  word_t Data_din;
  logic  Data_rd;
  logic  D_macc;
  word_t Data_dout;
  logic  complete_data;

  modport master (
    output pc, instrmem_rd, I_macc, Data_addr, Data_din, Data_rd, D_macc,
    input  Instr_dout, complete_instr, Data_dout, complete_data
  );

  modport slave (
    input  pc, instrmem_rd, I_macc, Data_addr, Data_din, Data_rd, D_macc,
    output Instr_dout, complete_instr, Data_dout, complete_data
  );

endinterface

// File: rtl/lc3_mem_port_fsm.sv
// Per-port IDLE/WAIT/DONE sequencer with a programmable wait-state count.
// `done` flags the edge that enters DONE so the top can register results there.
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
#(
  parameter int unsigned LAT = 1
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] extra_lat,
  output logic       accept,
  output logic       done
);

  localparam logic [4:0] LAT_W = 5'(LAT);

  mem_state_e state_r;
  mem_state_e state_s;
  logic [4:0] cnt_r;
  logic [4:0] cnt_s;

  // state and wait counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // next-state, counter and pulse decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s = WAIT;
          cnt_s   = LAT_W + {3'b000, extra_lat};
          accept  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        // a dropped request abandons the access without completing it
        if (!req) begin
          state_s = IDLE;
          cnt_s   = 5'd0;
        end else if (cnt_r == 5'd1) begin
          state_s = DONE;
          cnt_s   = 5'd0;
          done    = 1'b1;
        end else begin
          cnt_s = cnt_r - 5'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 5'd0;
      end
    endcase
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Unified word-addressed memory serving the LC3 fetch and data ports with wait states.
// Define LC3_MEM_RANDOM_STALL_EN to add 0..3 LFSR-driven extra wait states per access.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned I_LAT     = 1,
  parameter int unsigned D_LAT     = 2,
  parameter string       INIT_FILE = ""
)
(
  input logic               clock,
  input logic               reset,
  lc3_mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  word_t             mem_r [DEPTH];
  logic [ADDR_W-1:0] i_addr_r;
  logic [ADDR_W-1:0] d_addr_r;
  word_t             d_din_r;
  logic              d_rd_r;
  word_t             instr_dout_r;
  word_t             data_dout_r;
  logic              complete_instr_r;
  logic              complete_data_r;

  logic              i_req_s;
  logic              i_accept_s;
  logic              i_done_s;
  logic              d_accept_s;
  logic              d_done_s;
  logic [1:0]        i_extra_s;
  logic [1:0]        d_extra_s;
  logic              unused_hi_s;

  assign i_req_s     = bus.instrmem_rd & bus.I_macc;
  assign unused_hi_s = ^{bus.pc[15:ADDR_W], bus.Data_addr[15:ADDR_W]};

`ifdef LC3_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_r;

  // free-running stall pattern, restarted from the seed on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign i_extra_s = lfsr_r[1:0];
  assign d_extra_s = lfsr_r[1:0];
`else
  assign i_extra_s = 2'b00;
  assign d_extra_s = 2'b00;
`endif

  lc3_mem_port_fsm #(.LAT(I_LAT)) u_i_fsm (
    .clock     (clock),
    .reset     (reset),
    .req       (i_req_s),
    .extra_lat (i_extra_s),
    .accept    (i_accept_s),
    .done      (i_done_s)
  );

  lc3_mem_port_fsm #(.LAT(D_LAT)) u_d_fsm (
    .clock     (clock),
    .reset     (reset),
    .req       (bus.D_macc),
    .extra_lat (d_extra_s),
    .accept    (d_accept_s),
    .done      (d_done_s)
  );

  // capture request fields at accept; later input changes are ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      i_addr_r <= {ADDR_W{1'b0}};
      d_addr_r <= {ADDR_W{1'b0}};
      d_din_r  <= 16'h0000;
      d_rd_r   <= 1'b0;
    end else begin
      if (i_accept_s) begin
        i_addr_r <= bus.pc[ADDR_W-1:0];
      end else begin
        i_addr_r <= i_addr_r;
      end
      if (d_accept_s) begin
        d_addr_r <= bus.Data_addr[ADDR_W-1:0];
        d_din_r  <= bus.Data_din;
        d_rd_r   <= bus.Data_rd;
      end else begin
        d_addr_r <= d_addr_r;
        d_din_r  <= d_din_r;
        d_rd_r   <= d_rd_r;
      end
    end
  end

  // registered read data and one-cycle completion pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_dout_r     <= 16'h0000;
      data_dout_r      <= 16'h0000;
      complete_instr_r <= 1'b0;
      complete_data_r  <= 1'b0;
    end else begin
      complete_instr_r <= i_done_s;
      complete_data_r  <= d_done_s;
      if (i_done_s) begin
        instr_dout_r <= mem_r[i_addr_r];
      end else begin
        instr_dout_r <= instr_dout_r;
      end
      if (d_done_s && d_rd_r) begin
        data_dout_r <= mem_r[d_addr_r];
      end else begin
        data_dout_r <= data_dout_r;
      end
    end
  end

  // single write port; a same-edge fetch of this word still sees the old value
  always_ff @(posedge clock) begin
    if (!reset && d_done_s && !d_rd_r) begin
      mem_r[d_addr_r] <= d_din_r;
    end
  end

  assign bus.Instr_dout     = instr_dout_r;
  assign bus.Data_dout      = data_dout_r;
  assign bus.complete_instr = complete_instr_r;
  assign bus.complete_data  = complete_data_r;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed plus randomized bench for lc3_mem_responder against a word-array reference.
module tb_lc3_mem_responder;
  import lc3_mem_pkg::*;

  localparam int I_LAT = 1;
  localparam int D_LAT = 2;

  logic clock;
  logic reset;
  lc3_mem_responder_if bus();

  lc3_mem_responder #(.ADDR_W(8), .I_LAT(I_LAT), .D_LAT(D_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  word_t ref_mem [256];
  bit    ref_ok  [256];
  word_t exp_data_dout;
  word_t exp_instr_dout;
  int    n_checks;
  int    n_fail;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_latency(input string tag, input int n, input int lat);
`ifdef LC3_MEM_RANDOM_STALL_EN
    chk({tag, " latency"}, 16'((n >= lat && n <= lat + 3) ? 1 : 0), 16'd1);
`else
    chk({tag, " latency"}, 16'(n), 16'(lat));
`endif
  endtask

  task automatic data_access(input string tag, input logic [15:0] addr,
                             input logic [15:0] din, input logic rd);
    int   n;
    logic got;
    bus.Data_addr = addr;
    bus.Data_din  = din;
    bus.Data_rd   = rd;
    bus.D_macc    = 1'b1;
    tick();
    bus.Data_addr = ~addr;
    bus.Data_din  = ~din;
    n   = 0;
    got = 1'b0;
    while (!got && n < 24) begin
      tick();
      n++;
      got = bus.complete_data;
    end
    chk_latency(tag, n, D_LAT);
    bus.D_macc = 1'b0;
    if (rd) begin
      exp_data_dout = ref_mem[addr[7:0]];
    end else begin
      ref_mem[addr[7:0]] = din;
      ref_ok[addr[7:0]]  = 1'b1;
    end
    chk({tag, " Data_dout"}, bus.Data_dout, exp_data_dout);
    tick();
    chk({tag, " pulse width"}, 16'(bus.complete_data), 16'd0);
  endtask

  task automatic fetch(input string tag, input logic [15:0] addr);
    int   n;
    logic got;
    bus.pc          = addr;
    bus.instrmem_rd = 1'b1;
    bus.I_macc      = 1'b1;
    tick();
    bus.pc = ~addr;
    n   = 0;
    got = 1'b0;
    while (!got && n < 24) begin
      tick();
      n++;
      got = bus.complete_instr;
    end
    chk_latency(tag, n, I_LAT);
    bus.instrmem_rd = 1'b0;
    bus.I_macc      = 1'b0;
    exp_instr_dout  = ref_mem[addr[7:0]];
    chk({tag, " Instr_dout"}, bus.Instr_dout, exp_instr_dout);
    tick();
    chk({tag, " pulse width"}, 16'(bus.complete_instr), 16'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " Instr_dout"}, bus.Instr_dout, 16'h0000);
    chk({tag, " Data_dout"}, bus.Data_dout, 16'h0000);
    chk({tag, " complete_instr"}, 16'(bus.complete_instr), 16'd0);
    chk({tag, " complete_data"}, 16'(bus.complete_data), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    int          n;
    logic [15:0] a;
    logic [15:0] d;
    n_checks        = 0;
    n_fail          = 0;
    exp_data_dout   = 16'h0000;
    exp_instr_dout  = 16'h0000;
    bus.pc          = 16'h0000;
    bus.instrmem_rd = 1'b0;
    bus.I_macc      = 1'b0;
    bus.Data_addr   = 16'h0000;
    bus.Data_din    = 16'h0000;
    bus.Data_rd     = 1'b0;
    bus.D_macc      = 1'b0;
    reset           = 1'b1;
    tick();
    tick();
    chk_outputs_zero("reset");
    reset = 1'b0;

    data_access("seed10", 16'h0010, 16'h1234, 1'b0);
    data_access("seed30", 16'h0030, 16'h1111, 1'b0);
    data_access("seed50", 16'h0050, 16'h4444, 1'b0);
    data_access("seed60", 16'h0060, 16'h6666, 1'b0);

    // held fetch: two completions, both returning the same word
    bus.pc          = 16'h0010;
    bus.instrmem_rd = 1'b1;
    bus.I_macc      = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!bus.complete_instr && n < 24) begin
        tick();
        n++;
      end
      chk("held fetch seen", 16'(bus.complete_instr), 16'd1);
      chk("held fetch Instr_dout", bus.Instr_dout, 16'h1234);
      tick();
      chk("held fetch pulse width", 16'(bus.complete_instr), 16'd0);
    end
    bus.instrmem_rd = 1'b0;
    bus.I_macc      = 1'b0;
    tick();
    tick();
    tick();
    exp_instr_dout = 16'h1234;

    // instrmem_rd without I_macc is not a request
    bus.pc          = 16'h0030;
    bus.instrmem_rd = 1'b1;
    seen            = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | int'(bus.complete_instr);
    end
    chk("no I_macc no fetch", 16'(seen), 16'd0);
    bus.instrmem_rd = 1'b0;

    data_access("store beef", 16'h0020, 16'hBEEF, 1'b0);
    data_access("load beef", 16'h0020, 16'h0000, 1'b1);
    chk("load beef value", bus.Data_dout, 16'hBEEF);

    // abort a store by dropping D_macc in WAIT
    bus.Data_addr = 16'h0030;
    bus.Data_din  = 16'h5555;
    bus.Data_rd   = 1'b0;
    bus.D_macc    = 1'b1;
    tick();
    bus.D_macc = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | int'(bus.complete_data);
    end
    chk("abort no pulse", 16'(seen), 16'd0);
    data_access("abort readback", 16'h0030, 16'h0000, 1'b1);
    chk("abort old value", bus.Data_dout, 16'h1111);

    data_access("alias store", 16'h0140, 16'hA5A5, 1'b0);
    data_access("alias load", 16'h0040, 16'h0000, 1'b1);
    chk("alias value", bus.Data_dout, 16'hA5A5);

`ifndef LC3_MEM_RANDOM_STALL_EN
    // store and fetch of 0x50 finish on the same edge: fetch sees the old word
    bus.Data_addr = 16'h0050;
    bus.Data_din  = 16'h9999;
    bus.Data_rd   = 1'b0;
    bus.D_macc    = 1'b1;
    tick();
    bus.pc          = 16'h0050;
    bus.instrmem_rd = 1'b1;
    bus.I_macc      = 1'b1;
    tick();
    tick();
    chk("conflict complete_data", 16'(bus.complete_data), 16'd1);
    chk("conflict complete_instr", 16'(bus.complete_instr), 16'd1);
    chk("conflict Instr_dout", bus.Instr_dout, 16'h4444);
    chk("conflict Data_dout", bus.Data_dout, exp_data_dout);
    bus.D_macc      = 1'b0;
    bus.instrmem_rd = 1'b0;
    bus.I_macc      = 1'b0;
    tick();
    ref_mem[8'h50] = 16'h9999;
    fetch("conflict refetch", 16'h0050);
    chk("conflict new value", bus.Instr_dout, 16'h9999);
`endif

    // reset in the middle of a store
    bus.Data_addr = 16'h0060;
    bus.Data_din  = 16'h7777;
    bus.Data_rd   = 1'b0;
    bus.D_macc    = 1'b1;
    tick();
    reset      = 1'b1;
    bus.D_macc = 1'b0;
    tick();
    chk_outputs_zero("mid reset");
    reset          = 1'b0;
    exp_data_dout  = 16'h0000;
    exp_instr_dout = 16'h0000;
    tick();
    chk_outputs_zero("after reset");
    data_access("reset readback", 16'h0060, 16'h0000, 1'b1);
    chk("reset no write", bus.Data_dout, 16'h6666);

    // random mix against the reference array
    for (int i = 0; i < 40; i++) begin
      a = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
      d = 16'($urandom);
      n = int'($urandom_range(0, 2));
      if (n == 0 || !ref_ok[a[7:0]]) begin
        data_access("rand store", a, d, 1'b0);
      end else if (n == 1) begin
        data_access("rand load", a, d, 1'b1);
      end else begin
        fetch("rand fetch", a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
